dac_tx: RTL and testbench

- PCM playback source for the DAC path.
- Host software loads a waveform into an internal sample RAM through a 32-bit register port.
- While dac_run is high, the block replays the stored samples in a continuous loop on a valid/ready stream.
- Downstream consumers are the DAC interpolator and the pcm2udp capture path.

---
 rtl/dac_tx_pkg.sv | 19 +
 rtl/dac_sample_ram.sv | 31 +++
 rtl/dac_tx.sv | 155 +++++++++++++++
 tb/tb_dac_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_tx_pkg.sv
// Shared constants, playback FSM states and the register word packing helper for dac_tx.
package dac_tx_pkg;

   localparam int SAMPLE_W = 16;
   localparam int WORD_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_STREAM
   } dac_state_e;

   // Register word layout: even sample in the low half, odd sample in the high half.
   function automatic logic [WORD_W-1:0] pcm_pack(input logic [SAMPLE_W-1:0] s_even,
                                                   input logic [SAMPLE_W-1:0] s_odd);
      return {s_odd, s_even};
   endfunction

endpackage

// File: rtl/dac_sample_ram.sv
// Simple dual-port 32-bit sample RAM: port A read/write for the register side, port B read-only.
// Both read ports are registered (latency 1); port B returns RD_WORDS consecutive words.
module dac_sample_ram
   import dac_tx_pkg::*;
#(
   parameter int AW       = 9,
   parameter int RD_WORDS = 1
) (
   input  logic                       i_clk,
   input  logic                       i_a_wr,
   input  logic [AW-1:0]              i_a_addr,
   input  logic [WORD_W-1:0]          i_a_wdata,
   output logic [WORD_W-1:0]          o_a_rdata,
   input  logic [AW-1:0]              i_b_addr,
   output logic [RD_WORDS*WORD_W-1:0] o_b_rdata
);

   logic [WORD_W-1:0] r_mem [2**AW];

   // Reads return the pre-write contents when both ports hit the same word.
   always_ff @(posedge i_clk) begin
      if (i_a_wr) begin
         r_mem[i_a_addr] <= i_a_wdata;
      end
      o_a_rdata <= r_mem[i_a_addr];
      for (int k = 0; k < RD_WORDS; k++) begin
         o_b_rdata[k*WORD_W +: WORD_W] <= r_mem[i_b_addr + AW'(k)];
      end
   end

endmodule

// File: rtl/dac_tx.sv
// PCM playback source: replays a host-loaded waveform in a loop on a valid/ready stream.
// First beat 2 cycles after dac_run is sampled; beat and valid are held stable while ready is low.
module dac_tx
   import dac_tx_pkg::*;
#(
   parameter int CHANNEL = 1,
   parameter int pcmaw   = 10
) (
   input  logic                        pcm_clk,
   input  logic                        rst,
   output logic                        dac_pcm_out_valid,
   input  logic                        dac_pcm_out_ready,
   output logic [SAMPLE_W*CHANNEL-1:0] dac_pcm_out,
   input  logic [15:0]                 reg_addr,
   input  logic                        reg_rd,
   input  logic                        reg_wr,
   output logic                        reg_ready,
   input  logic [WORD_W-1:0]           reg_writedata,
   output logic [WORD_W-1:0]           reg_readdata,
   input  logic [pcmaw-1:0]            dac_signal_len,
   input  logic [7:0]                  dac_cic_rate,
   input  logic                        dac_run
);

   localparam int BEAT_W   = SAMPLE_W*CHANNEL;
   localparam int WAW      = pcmaw-1;
   localparam int RD_WORDS = (CHANNEL+1)/2;
   localparam logic [pcmaw-1:0] CH_P = pcmaw'(CHANNEL);

   dac_state_e             r_state;
   logic [pcmaw-1:0]       r_ptr;
   logic [pcmaw-1:0]       r_len;
   logic [7:0]             r_rate;
   logic [7:0]             r_hold;
   logic                   r_valid;
   logic [BEAT_W-1:0]      r_out;
   logic                   r_q_odd;
   logic                   r_rd_busy;

   logic [WORD_W-1:0]          w_qa;
   logic [RD_WORDS*WORD_W-1:0] w_qb;
   logic [BEAT_W-1:0]          w_beat;
   logic [pcmaw-1:0]           w_nptr;
   logic [pcmaw-1:0]           w_nnptr;
   logic [pcmaw-1:0]           w_rd_ptr;
   logic                       w_fire;
   logic                       w_adv;
   logic                       w_unused_addr;

   // Pointer step modulo the latched length; p+CHANNEL never exceeds 2*len.
   function automatic logic [pcmaw-1:0] step(input logic [pcmaw-1:0] p,
                                             input logic [pcmaw-1:0] len);
      logic [pcmaw:0] s;
      s = {1'b0, p} + {1'b0, CH_P};
      if (s >= {1'b0, len}) begin
         s = s - {1'b0, len};
      end
      return s[pcmaw-1:0];
   endfunction

   assign w_nptr  = step(r_ptr, r_len);
   assign w_nnptr = step(w_nptr, r_len);
   assign w_fire  = r_valid & dac_pcm_out_ready;
   assign w_adv   = (r_state == ST_STREAM) & w_fire & (r_hold == r_rate);

   // Port B always holds the beat that follows the one on the output, so an advance never bubbles.
   always_comb begin
      w_rd_ptr = '0;
      case (r_state)
         ST_IDLE:   w_rd_ptr = '0;
         ST_FETCH:  w_rd_ptr = w_nptr;
         ST_STREAM: w_rd_ptr = w_adv ? w_nnptr : w_nptr;
         default:   w_rd_ptr = '0;
      endcase
   end

   dac_sample_ram #(
      .AW       (WAW),
      .RD_WORDS (RD_WORDS)
   ) u_ram (
      .i_clk     (pcm_clk),
      .i_a_wr    (reg_wr),
      .i_a_addr  (reg_addr[WAW-1:0]),
      .i_a_wdata (reg_writedata),
      .o_a_rdata (w_qa),
      .i_b_addr  (w_rd_ptr[pcmaw-1:1]),
      .o_b_rdata (w_qb)
   );

   generate
      if (CHANNEL % 2 == 0) begin : g_even
         assign w_beat = w_qb;
      end else begin : g_odd
         assign w_beat = w_qb[(r_q_odd ? SAMPLE_W : 0) +: BEAT_W];
      end
   endgenerate

   assign w_unused_addr = ^reg_addr[15:WAW];

   always_ff @(posedge pcm_clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_len     <= '0;
         r_rate    <= '0;
         r_hold    <= '0;
         r_valid   <= 1'b0;
         r_out     <= '0;
         r_q_odd   <= 1'b0;
         r_rd_busy <= 1'b0;
      end else begin
         r_rd_busy <= reg_rd & ~reg_wr & ~r_rd_busy;
         r_q_odd   <= w_rd_ptr[0];
         if (!dac_run) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (dac_signal_len >= CH_P) begin
                     r_len   <= dac_signal_len;
                     r_rate  <= dac_cic_rate;
                     r_ptr   <= '0;
                     r_hold  <= '0;
                     r_state <= ST_FETCH;
                  end
               end
               ST_FETCH: begin
                  r_out   <= w_beat;
                  r_valid <= 1'b1;
                  r_state <= ST_STREAM;
               end
               ST_STREAM: begin
                  if (w_fire) begin
                     if (r_hold == r_rate) begin
                        r_hold <= '0;
                        r_ptr  <= w_nptr;
                        r_out  <= w_beat;
                     end else begin
                        r_hold <= r_hold + 8'd1;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign dac_pcm_out_valid = r_valid;
   assign dac_pcm_out       = r_out;
   assign reg_ready         = reg_wr | r_rd_busy;
   assign reg_readdata      = r_rd_busy ? w_qa : '0;

endmodule

// File: tb/tb_dac_tx.sv
// Randomized bench for dac_tx: a sample-array model predicts every accepted beat and register read.
module tb_dac_tx;

   localparam int CH = 1;
   localparam int AW = 10;

   logic          pcm_clk = 1'b0;
   logic          rst = 1'b1;
   logic          dac_pcm_out_valid;
   logic          dac_pcm_out_ready = 1'b0;
   logic [15:0]   dac_pcm_out;
   logic [15:0]   reg_addr = '0;
   logic          reg_rd = 1'b0;
   logic          reg_wr = 1'b0;
   logic          reg_ready;
   logic [31:0]   reg_writedata = '0;
   logic [31:0]   reg_readdata;
   logic [AW-1:0] dac_signal_len = '0;
   logic [7:0]    dac_cic_rate = '0;
   logic          dac_run = 1'b0;

   logic [15:0] mem [0:1023];
   int errors = 0;
   int checks = 0;

   dac_tx #(.CHANNEL(CH), .pcmaw(AW)) dut (
      .pcm_clk           (pcm_clk),
      .rst               (rst),
      .dac_pcm_out_valid (dac_pcm_out_valid),
      .dac_pcm_out_ready (dac_pcm_out_ready),
      .dac_pcm_out       (dac_pcm_out),
      .reg_addr          (reg_addr),
      .reg_rd            (reg_rd),
      .reg_wr            (reg_wr),
      .reg_ready         (reg_ready),
      .reg_writedata     (reg_writedata),
      .reg_readdata      (reg_readdata),
      .dac_signal_len    (dac_signal_len),
      .dac_cic_rate      (dac_cic_rate),
      .dac_run           (dac_run)
   );

   always #5 pcm_clk = ~pcm_clk;

   task automatic tick();
      @(posedge pcm_clk);
      #1;
   endtask

   task automatic wr_word(input int a, input logic [31:0] d);
      reg_addr = 16'(a);
      reg_writedata = d;
      reg_wr = 1'b1;
      tick();
      reg_wr = 1'b0;
      mem[2*a]   = d[15:0];
      mem[2*a+1] = d[31:16];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (dac_pcm_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dac_pcm_out_valid); end
      checks++; if (dac_pcm_out !== 16'h0) begin errors++; $display("FAIL reset_out: got %h expected 0000", dac_pcm_out); end
      checks++; if (reg_ready !== 1'b0) begin errors++; $display("FAIL reset_reg_ready: got %b expected 0", reg_ready); end
      checks++; if (reg_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", reg_readdata); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load();
      logic [31:0] d;
      for (int k = 0; k < 16; k++) begin
         d = {16'(2*k+1), 16'(2*k)};
         reg_addr = 16'(k);
         reg_writedata = d;
         reg_wr = 1'b1;
         #1;
         checks++; if (reg_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d]: got %b expected 1", k, reg_ready); end
         mem[2*k]   = d[15:0];
         mem[2*k+1] = d[31:16];
         @(posedge pcm_clk);
         #1;
      end
      reg_wr = 1'b0;
   endtask

   task automatic test_read();
      int n;
      reg_addr = 16'd3;
      reg_rd = 1'b1;
      #1;
      checks++; if (reg_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_early: got %b expected 0", reg_ready); end
      tick();
      checks++; if (reg_ready !== 1'b1 || reg_readdata !== 32'h00070006) begin errors++; $display("FAIL rd_addr3: got ready=%b data=%h expected ready=1 data=00070006", reg_ready, reg_readdata); end
      reg_rd = 1'b0;
      tick();
      checks++; if (reg_ready !== 1'b0 || reg_readdata !== 32'h0) begin errors++; $display("FAIL rd_one_cycle: got ready=%b data=%h expected ready=0 data=0", reg_ready, reg_readdata); end
      // upper address bits are ignored
      reg_addr = 16'h8003;
      reg_rd = 1'b1;
      tick();
      checks++; if (reg_ready !== 1'b1 || reg_readdata !== 32'h00070006) begin errors++; $display("FAIL rd_alias: got ready=%b data=%h expected ready=1 data=00070006", reg_ready, reg_readdata); end
      reg_rd = 1'b0;
      tick();
      // simultaneous read and write: the write wins, no read completion follows
      reg_addr = 16'd20;
      reg_writedata = 32'hCAFEBABE;
      reg_wr = 1'b1;
      reg_rd = 1'b1;
      #1;
      checks++; if (reg_ready !== 1'b1) begin errors++; $display("FAIL wr_wins_ready: got %b expected 1", reg_ready); end
      tick();
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      mem[40] = 16'hBABE;
      mem[41] = 16'hCAFE;
      #1;
      checks++; if (reg_ready !== 1'b0) begin errors++; $display("FAIL wr_wins_no_read: got %b expected 0", reg_ready); end
      reg_rd = 1'b1;
      n = 0;
      tick();
      while (reg_ready !== 1'b1 && n < 4) begin tick(); n++; end
      checks++; if (reg_ready !== 1'b1 || reg_readdata !== {mem[41], mem[40]}) begin errors++; $display("FAIL wr_wins_readback: got ready=%b data=%h expected ready=1 data=%h", reg_ready, reg_readdata, {mem[41], mem[40]}); end
      reg_rd = 1'b0;
      tick();
   endtask

   task automatic run_stream(input int len, input int rate, input int rmode, input int nbeats, input string name);
      int idx;
      int rep;
      int got;
      int cyc;
      logic hold_chk;
      logic [15:0] held;
      idx = 0; rep = 0; got = 0; cyc = 0; hold_chk = 1'b0; held = '0;
      dac_signal_len = AW'(len);
      dac_cic_rate = 8'(rate);
      dac_pcm_out_ready = 1'b1;
      dac_run = 1'b1;
      tick();
      checks++; if (dac_pcm_out_valid !== 1'b0) begin errors++; $display("FAIL %s_lat1: got valid=%b expected 0", name, dac_pcm_out_valid); end
      tick();
      checks++; if (dac_pcm_out_valid !== 1'b1) begin errors++; $display("FAIL %s_lat2: got valid=%b expected 1", name, dac_pcm_out_valid); end
      while (got < nbeats && cyc < 4000) begin
         if (hold_chk) begin
            checks++; if (dac_pcm_out_valid !== 1'b1 || dac_pcm_out !== held) begin errors++; $display("FAIL %s_stable: got valid=%b out=%h expected valid=1 out=%h", name, dac_pcm_out_valid, dac_pcm_out, held); end
         end
         if (rmode == 0) begin
            checks++; if (dac_pcm_out_valid !== 1'b1) begin errors++; $display("FAIL %s_bubble: got valid=%b expected 1 at beat %0d", name, dac_pcm_out_valid, got); end
         end
         if (rmode == 1) dac_pcm_out_ready = ~dac_pcm_out_ready;
         else if (rmode == 2) dac_pcm_out_ready = 1'($urandom_range(0, 1));
         if (dac_pcm_out_valid === 1'b1 && dac_pcm_out_ready) begin
            checks++; if (dac_pcm_out !== mem[idx]) begin errors++; $display("FAIL %s_beat[%0d]: got %h expected %h (sample %0d)", name, got, dac_pcm_out, mem[idx], idx); end
            got++;
            rep++;
            if (rep == rate + 1) begin
               rep = 0;
               idx = (idx + CH) % len;
            end
         end
         hold_chk = (dac_pcm_out_valid === 1'b1) && !dac_pcm_out_ready;
         held = dac_pcm_out;
         tick();
         cyc++;
      end
      checks++; if (got < nbeats) begin errors++; $display("FAIL %s_timeout: got %0d beats expected %0d", name, got, nbeats); end
      dac_run = 1'b0;
      tick();
      checks++; if (dac_pcm_out_valid !== 1'b0) begin errors++; $display("FAIL %s_stop: got valid=%b expected 0", name, dac_pcm_out_valid); end
      dac_pcm_out_ready = 1'b0;
      tick();
   endtask

   task automatic test_len_zero();
      dac_signal_len = '0;
      dac_cic_rate = '0;
      dac_pcm_out_ready = 1'b1;
      dac_run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (dac_pcm_out_valid !== 1'b0) begin errors++; $display("FAIL len_zero[%0d]: got valid=%b expected 0", i, dac_pcm_out_valid); end
      end
      dac_run = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      dac_signal_len = AW'(32);
      dac_cic_rate = '0;
      dac_pcm_out_ready = 1'b1;
      dac_run = 1'b1;
      repeat (6) tick();
      checks++; if (dac_pcm_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_running: got valid=%b expected 1", dac_pcm_out_valid); end
      rst = 1'b1;
      tick();
      checks++; if (dac_pcm_out_valid !== 1'b0 || dac_pcm_out !== 16'h0) begin errors++; $display("FAIL rstmid_outputs: got valid=%b out=%h expected valid=0 out=0000", dac_pcm_out_valid, dac_pcm_out); end
      dac_run = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int a;
      int n;
      int len;
      for (int w = 0; w < 256; w++) wr_word(w, $urandom);
      for (int r = 0; r < 4; r++) begin
         a = $urandom_range(0, 255);
         reg_addr = 16'(a);
         reg_rd = 1'b1;
         n = 0;
         tick();
         while (reg_ready !== 1'b1 && n < 4) begin tick(); n++; end
         checks++; if (reg_ready !== 1'b1 || reg_readdata !== {mem[2*a+1], mem[2*a]}) begin errors++; $display("FAIL rand_read[%0d]: got ready=%b data=%h expected ready=1 data=%h", a, reg_ready, reg_readdata, {mem[2*a+1], mem[2*a]}); end
         reg_rd = 1'b0;
         tick();
      end
      for (int r = 0; r < 3; r++) begin
         len = $urandom_range(1, 511);
         run_stream(len, $urandom_range(0, 3), 2, 120, $sformatf("rand%0d", r));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load();
      test_read();
      run_stream(32, 0, 0, 70, "plain");
      run_stream(32, 0, 1, 40, "toggle");
      run_stream(32, 2, 0, 30, "cic");
      run_stream(32, 0, 0, 10, "restart_a");
      run_stream(32, 0, 0, 5, "restart_b");
      test_len_zero();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
